// File: rtl/lio_i8080_pkg.sv
// Shared definitions for the i8080-bus display target model:
// command opcodes, the target FSM states and the filler pattern
// returned by reads that have nothing to return.
package lio_i8080_pkg;

  localparam logic [7:0]  CMD_MEMWR    = 8'h1C;
  localparam logic [7:0]  CMD_MEMRD    = 8'h1D;
  localparam logic [7:0]  CMD_SETADDR  = 8'h2A;
  localparam logic [7:0]  CMD_STATUS   = 8'h0A;
  localparam logic [7:0]  CMD_SWRST    = 8'h01;

  localparam logic [15:0] DEAD_PATTERN = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    ADDR,
    STAT
  } fsm_e;

  // Error counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lio_i8080_strobe_sync.sv
// Synchronizer plus edge detector for one asynchronous bus strobe.
// The level output and the rise/fall pulses are aligned: both appear
// SYNC_STAGES+1 clocks after the pin changes.
module lio_i8080_strobe_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;

  // Metastability chain; resets to the idle level of the strobe so that
  // leaving reset never produces a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], a};
    end
  end

  // Edge-detect stage: registered level and one-cycle edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl  <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      lvl  <= sync_p[SYNC_STAGES-1];
      rise <= sync_p[SYNC_STAGES-1] & ~lvl;
      fall <= ~sync_p[SYNC_STAGES-1] & lvl;
    end
  end

endmodule

// File: rtl/lio_i8080_target_model.sv
// i8080-bus display target with internal byte-wide frame memory.
// Strobes are oversampled; commands select write, read, address-set and
// status modes, and protocol violations are counted.
module lio_i8080_target_model
  import lio_i8080_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,  // 8 or 16
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2    // at least 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_16b,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] d_o,
  output logic                  d_oe,
  input  logic                  ce,
  input  logic                  dc,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  err_pulse,
  output logic [7:0]            err_cnt,
  output logic [7:0]            cur_cmd
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB        = (ADDR_WIDTH + 7) / 8;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

  // Synchronised strobe levels and edges
  logic ce_l, ce_rise, ce_fall;
  logic dc_l, dc_rise, dc_fall;
  logic rd_l, rd_rise, rd_fall;
  logic wr_l, wr_rise, wr_fall;
  logic unused_edges;

  lio_i8080_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ce_sync (
    .clk(clk), .rst(rst), .a(ce), .lvl(ce_l), .rise(ce_rise), .fall(ce_fall));
  lio_i8080_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dc_sync (
    .clk(clk), .rst(rst), .a(dc), .lvl(dc_l), .rise(dc_rise), .fall(dc_fall));
  lio_i8080_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd_sync (
    .clk(clk), .rst(rst), .a(rd), .lvl(rd_l), .rise(rd_rise), .fall(rd_fall));
  lio_i8080_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr_sync (
    .clk(clk), .rst(rst), .a(wr), .lvl(wr_l), .rise(wr_rise), .fall(wr_fall));

  // Edges this target has no use for.
  assign unused_edges = ^{ce_fall, dc_rise, dc_fall, wr_fall};

  // Bus data delayed to line up with the synchronised strobes
  logic [DATA_WIDTH-1:0] d_dly_p [SYNC_STAGES+1];
  logic [15:0]           d16;

  // Data delay line; pure data, so no reset.
  always_ff @(posedge clk) begin
    d_dly_p[0] <= d_i;
    for (int i = 1; i <= SYNC_STAGES; i++) begin
      d_dly_p[i] <= d_dly_p[i-1];
    end
  end

  assign d16 = 16'(d_dly_p[SYNC_STAGES]);

  // State
  fsm_e                  state;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [3:0]            byte_idx;
  logic                  coll;
  logic                  d_oe_r;
  logic [7:0]            mem [MEM_DEPTH];

  // Derived qualifiers
  logic                    wide;
  logic [ADDR_WIDTH-1:0]   step;
  logic [ADDR_WIDTH-1:0]   wr_ptr_p1;
  logic [ADDR_WIDTH-1:0]   rd_ptr_p1;
  logic [ADDR_WIDTH+7:0]   addr_shift;
  logic                    both_low;
  logic                    wr_ok, cmd_ev, dat_ev, mem_we;
  logic                    rd_go, rd_end;
  logic                    err_now;
  logic [15:0]             rdata16;
  logic                    rd_bad;

  assign wide       = bus_16b && (DATA_WIDTH == 16);
  assign step       = wide ? TWO : ONE;
  assign wr_ptr_p1  = wr_ptr + ONE;
  assign rd_ptr_p1  = rd_ptr + ONE;
  assign addr_shift = {start_addr, d16[7:0]};
  assign both_low   = ~rd_l & ~wr_l;

  // A write or read only counts when selected and not overlapping the other strobe.
  assign wr_ok  = wr_rise & ~ce_l & ~coll & rd_l;
  assign cmd_ev = wr_ok & ~dc_l;
  assign dat_ev = wr_ok & dc_l;
  assign mem_we = dat_ev & (state == WR);
  assign rd_go  = rd_fall & ~ce_l & wr_l & ~coll;
  assign rd_end = rd_rise & ~ce_l & ~coll & d_oe_r;

  // Read data source for the current mode.
  always_comb begin
    rdata16 = DEAD_PATTERN;
    rd_bad  = 1'b1;
    case (state)
      RD: begin
        rd_bad  = 1'b0;
        rdata16 = {(wide ? mem[rd_ptr_p1] : 8'h00), mem[rd_ptr]};
      end
      STAT: begin
        rd_bad  = 1'b0;
        rdata16 = {(wide ? 8'(wr_ptr) : 8'h00), err_cnt};
      end
      default: ;
    endcase
  end

  assign err_now = ((wr_rise | rd_fall) & ce_l)
                 | (both_low & ~coll)
                 | (rd_go & rd_bad);

  // Deselecting the target releases the bus without waiting for the synchroniser.
  assign d_oe = d_oe_r & ~ce;

  // Frame memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= d16[7:0];
      if (wide) begin
        mem[wr_ptr_p1] <= d16[15:8];
      end
    end
  end

  // Command decode, pointers, read port and error accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      start_addr <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      byte_idx   <= '0;
      coll       <= 1'b0;
      d_oe_r     <= 1'b0;
      d_o        <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      cur_cmd    <= '0;
    end else begin
      err_pulse <= err_now;
      if (err_now) begin
        err_cnt <= sat_inc8(err_cnt);
      end

      // Overlap flag holds from the moment both strobes are low until both are high again.
      if (both_low) begin
        coll <= 1'b1;
      end else if (rd_l && wr_l) begin
        coll <= 1'b0;
      end

      if (rd_go) begin
        d_oe_r <= 1'b1;
        d_o    <= DATA_WIDTH'(rdata16);
      end
      if (rd_end || both_low || ce_l) begin
        d_oe_r <= 1'b0;
      end
      if (rd_end && state == RD) begin
        rd_ptr <= rd_ptr + step;
      end

      if (cmd_ev) begin
        cur_cmd <= d16[7:0];
        state   <= IDLE;
        case (d16[7:0])
          CMD_MEMWR: begin
            state  <= WR;
            wr_ptr <= start_addr;
          end
          CMD_MEMRD: begin
            state  <= RD;
            rd_ptr <= start_addr;
          end
          CMD_SETADDR: begin
            state    <= ADDR;
            byte_idx <= '0;
          end
          CMD_STATUS: begin
            state <= STAT;
          end
          CMD_SWRST: begin
            cur_cmd    <= '0;
            start_addr <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_idx   <= '0;
            err_cnt    <= '0;
          end
          default: ;
        endcase
      end

      if (dat_ev) begin
        case (state)
          WR: begin
            wr_ptr <= wr_ptr + step;
          end
          ADDR: begin
            start_addr <= addr_shift[ADDR_WIDTH-1:0];
            if (byte_idx == 4'(NB - 1)) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
            end
          end
          default: ;
        endcase
      end

      // Deselect reloads both pointers; placed last so it beats a same-cycle rd rise.
      if (ce_rise) begin
        rd_ptr <= start_addr;
        wr_ptr <= start_addr;
      end
    end
  end

endmodule

// File: tb/tb_lio_i8080_target_model.sv
// Directed plus randomised bench for the i8080 target model, checked
// against a transaction-level reference model of the target.
module tb_lio_i8080_target_model;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int SS = 2;

  localparam int S_IDLE = 0;
  localparam int S_WR   = 1;
  localparam int S_RD   = 2;
  localparam int S_ADDR = 3;
  localparam int S_STAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          bus_16b;
  logic [DW-1:0] d_i;
  logic [DW-1:0] d_o;
  logic          d_oe;
  logic          ce, dc, rd, wr;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic [7:0]    cur_cmd;

  always #5 clk = ~clk;

  lio_i8080_target_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .bus_16b(bus_16b), .d_i(d_i), .d_o(d_o), .d_oe(d_oe),
    .ce(ce), .dc(dc), .rd(rd), .wr(wr),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .cur_cmd(cur_cmd)
  );

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  int         m_state;
  logic [7:0] m_start, m_wp, m_rp, m_cur, m_err;
  int         m_nerr;

  always @(negedge clk) begin
    if (err_pulse === 1'b1) pulses++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_state = S_IDLE;
    m_start = 8'h00;
    m_wp    = 8'h00;
    m_rp    = 8'h00;
    m_cur   = 8'h00;
    m_err   = 8'h00;
  endtask

  task automatic m_error();
    m_nerr++;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  // Model of one accepted write cycle.
  task automatic m_write(input bit dcv, input logic [15:0] v);
    if (!dcv) begin
      m_cur = v[7:0];
      case (v[7:0])
        8'h1C: begin m_state = S_WR; m_wp = m_start; end
        8'h1D: begin m_state = S_RD; m_rp = m_start; end
        8'h2A: m_state = S_ADDR;
        8'h0A: m_state = S_STAT;
        8'h01: begin m_reset(); end
        default: m_state = S_IDLE;
      endcase
    end else begin
      case (m_state)
        S_WR: begin
          m_mem[m_wp] = v[7:0];
          if (bus_16b) begin
            m_mem[8'(m_wp + 8'd1)] = v[15:8];
            m_wp = m_wp + 8'd2;
          end else begin
            m_wp = m_wp + 8'd1;
          end
        end
        S_ADDR: begin
          m_start = v[7:0];
          m_state = S_IDLE;
        end
        default: ;
      endcase
    end
  endtask

  // Model of the value a read returns; also accounts for the bad-state error.
  task automatic m_read(output logic [15:0] v);
    case (m_state)
      S_RD:   v = bus_16b ? {m_mem[8'(m_rp + 8'd1)], m_mem[m_rp]} : {8'h00, m_mem[m_rp]};
      S_STAT: v = {(bus_16b ? m_wp : 8'h00), m_err};
      default: begin
        v = 16'hDEAD;
        m_error();
      end
    endcase
  endtask

  task automatic bus_wr(input bit dcv, input logic [15:0] v);
    dc  = dcv;
    d_i = v;
    cyc(4);
    wr = 1'b0;
    cyc(4);
    wr = 1'b1;
    cyc(5);
    m_write(dcv, v);
  endtask

  task automatic bus_rd(input string tag);
    int n;
    logic [15:0] exp;
    n  = 0;
    rd = 1'b0;
    while (d_oe !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk({tag, "_lat"}, n, SS + 2);
    m_read(exp);
    chk({tag, "_do"}, d_o, exp);
    rd = 1'b1;
    cyc(5);
    chk({tag, "_oe_off"}, d_oe, 1'b0);
    if (m_state == S_RD) m_rp = m_rp + (bus_16b ? 8'd2 : 8'd1);
  endtask

  initial begin
    int n;
    logic [7:0] a;
    logic [15:0] w;
    rst = 1'b1; bus_16b = 1'b0; d_i = '0;
    ce = 1'b1; dc = 1'b0; rd = 1'b1; wr = 1'b1;
    m_reset();
    m_nerr = 0;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    chk("rst_d_oe", d_oe, 1'b0);
    chk("rst_d_o", d_o, 16'h0000);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_cur_cmd", cur_cmd, 8'h00);
    ce = 1'b0;
    cyc(5);

    // 8-bit bus write then readback
    bus_wr(1'b0, 16'h001C);
    bus_wr(1'b1, 16'h0011);
    bus_wr(1'b1, 16'h0022);
    bus_wr(1'b1, 16'h0033);
    bus_wr(1'b0, 16'h001D);
    chk("cmd_memrd", cur_cmd, 8'h1D);
    bus_rd("rd8_0");
    bus_rd("rd8_1");
    bus_rd("rd8_2");

    // 16-bit bus write across the top of memory
    bus_16b = 1'b1;
    cyc(2);
    bus_wr(1'b0, 16'h002A);
    bus_wr(1'b1, 16'h00FE);
    bus_wr(1'b0, 16'h001C);
    bus_wr(1'b1, 16'hBBAA);
    bus_wr(1'b1, 16'hDDCC);
    bus_wr(1'b0, 16'h002A);
    bus_wr(1'b1, 16'h00FE);
    bus_wr(1'b0, 16'h001D);
    bus_rd("rd16_0");
    bus_rd("rd16_1");

    // Deselect reloads the read pointer
    ce = 1'b1;
    cyc(5);
    ce = 1'b0;
    cyc(5);
    m_rp = m_start;
    m_wp = m_start;
    bus_rd("rd_after_ce");

    // Protocol errors
    ce = 1'b1;
    cyc(5);
    wr = 1'b0;
    cyc(5);
    wr = 1'b1;
    cyc(5);
    ce = 1'b0;
    cyc(5);
    m_rp = m_start;
    m_wp = m_start;
    m_error();
    chk("err_ce_high", err_cnt, m_err);

    rd = 1'b0;
    wr = 1'b0;
    cyc(6);
    chk("collide_oe", d_oe, 1'b0);
    rd = 1'b1;
    wr = 1'b1;
    cyc(5);
    m_error();
    chk("err_collide", err_cnt, m_err);

    bus_wr(1'b0, 16'h0055);
    chk("cmd_other", cur_cmd, 8'h55);
    bus_rd("rd_dead");
    chk("err_cnt3", err_cnt, 8'd3);
    chk("err_pulses3", pulses, 3);

    // Status read and soft reset
    bus_wr(1'b0, 16'h000A);
    bus_rd("rd_status");
    bus_wr(1'b0, 16'h0001);
    chk("swrst_err", err_cnt, 8'h00);
    chk("swrst_cmd", cur_cmd, 8'h00);
    bus_wr(1'b0, 16'h001D);
    bus_rd("rd_after_swrst");

    // Randomised write/readback bursts
    for (int it = 0; it < 6; it++) begin
      bus_16b = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      n = $urandom_range(1, 4);
      cyc(2);
      bus_wr(1'b0, 16'h002A);
      bus_wr(1'b1, {8'h00, a});
      bus_wr(1'b0, 16'h001C);
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        bus_wr(1'b1, w);
      end
      bus_wr(1'b0, 16'h002A);
      bus_wr(1'b1, {8'h00, a});
      bus_wr(1'b0, 16'h001D);
      for (int k = 0; k < n; k++) begin
        bus_rd($sformatf("rnd%0d_%0d", it, k));
      end
    end

    // Reset during an active read
    bus_16b = 1'b1;
    bus_wr(1'b0, 16'h001D);
    n  = 0;
    rd = 1'b0;
    while (d_oe !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("mid_rd_oe", d_oe, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_oe", d_oe, 1'b0);
    cyc(2);
    rd = 1'b1;
    cyc(3);
    rst = 1'b0;
    m_reset();
    cyc(6);
    chk("post_rst_cmd", cur_cmd, 8'h00);
    chk("post_rst_err", err_cnt, 8'h00);
    chk("post_rst_oe", d_oe, 1'b0);
    chk("err_pulse_total", pulses, m_nerr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
